// File: rtl/t03_display_layer_ctrl_if.sv
// t03_display_layer_ctrl_if: layer update handshake (valid/ready plus target layer, x, y, enable) from game logic to the controller
interface t03_display_layer_ctrl_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [1:0]  upd_layer;
  logic [10:0] upd_x;
  logic [10:0] upd_y;
  logic        upd_en;
  modport master (output upd_valid, upd_layer, upd_x, upd_y, upd_en, input upd_ready);
  modport slave  (input upd_valid, upd_layer, upd_x, upd_y, upd_en, output upd_ready);
endinterface

// File: rtl/t03_display_layer_ctrl.sv
// t03_display_layer_ctrl: shadows layer updates, commits them in vblank, registers the priority-arbitrated pixel colour (ports: clk/rst, hcnt_i/vcnt_i, upd handshake, layer_hit_i/layer_color_i in, layer_x_o/layer_y_o/layer_en_o/pixel_color_o/frame_start_o out)
module t03_display_layer_ctrl #(
  parameter int          NUM_LAYERS = 4,
  parameter int          H_ACTIVE   = 800,
  parameter int          V_ACTIVE   = 600,
  parameter logic [7:0]  BG_COLOR   = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [10:0]                hcnt_i,
  input  logic [10:0]                vcnt_i,
  t03_display_layer_ctrl_if.slave    upd,
  input  logic [NUM_LAYERS-1:0]      layer_hit_i,
  input  logic [8*NUM_LAYERS-1:0]    layer_color_i,
  output logic [11*NUM_LAYERS-1:0]   layer_x_o,
  output logic [11*NUM_LAYERS-1:0]   layer_y_o,
  output logic [NUM_LAYERS-1:0]      layer_en_o,
  output logic [7:0]                 pixel_color_o,
  output logic                       frame_start_o
);
  typedef enum logic [1:0] {ACTIVE, COMMIT, BLANK} state_t;
  state_t                   state_q, state_d;
  logic [1:0]               idx_q, idx_d;
  logic [11*NUM_LAYERS-1:0] sx_q, sy_q, x_q, y_q;
  logic [NUM_LAYERS-1:0]    sen_q, en_q, dirty_q;
  logic [7:0]               pix_q, pix_d;
  logic                     fs_q, last, xfer, visible;
  assign last          = idx_q == 2'(NUM_LAYERS-1);
  assign upd.upd_ready = state_q != COMMIT;
  assign xfer          = upd.upd_valid && upd.upd_ready;
  assign visible       = hcnt_i < 11'(H_ACTIVE) && vcnt_i < 11'(V_ACTIVE);
  assign layer_x_o     = x_q;
  assign layer_y_o     = y_q;
  assign layer_en_o    = en_q;
  assign pixel_color_o = pix_q;
  assign frame_start_o = fs_q;
  always_comb begin
    state_d = state_q == ACTIVE ? ((vcnt_i == 11'(V_ACTIVE) && hcnt_i == 11'd0) ? COMMIT : ACTIVE)
            : state_q == COMMIT ? (last ? BLANK : COMMIT)
            : ((vcnt_i == 11'd0 && hcnt_i == 11'd0) ? ACTIVE : BLANK);
    idx_d = (state_q == COMMIT && !last) ? idx_q + 2'd1 : 2'd0;
    pix_d = BG_COLOR;
    // scan from lowest priority up so the lowest qualifying index is written last
    for (int i = NUM_LAYERS-1; i >= 0; i--)
      if (layer_hit_i[i] && en_q[i]) pix_d = layer_color_i[8*i +: 8];
    if (!visible) pix_d = 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      idx_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      sen_q   <= '0;
      dirty_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      en_q    <= '0;
      pix_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      fs_q    <= state_q == BLANK && state_d == ACTIVE;
      // transfers and commits never overlap: ready is low for the whole commit
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (xfer && upd.upd_layer == 2'(i)) begin
          sx_q[11*i +: 11] <= upd.upd_x;
          sy_q[11*i +: 11] <= upd.upd_y;
          sen_q[i]         <= upd.upd_en;
          dirty_q[i]       <= 1'b1;
        end
        if (state_q == COMMIT && idx_q == 2'(i) && dirty_q[i]) begin
          x_q[11*i +: 11] <= sx_q[11*i +: 11];
          y_q[11*i +: 11] <= sy_q[11*i +: 11];
          en_q[i]         <= sen_q[i];
          dirty_q[i]      <= 1'b0;
        end
      end
    end
  end
endmodule
